// File: rtl/regfile_wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_wb_arbiter_pkg
//  Purpose  : Shared register-file constants used by the writeback arbiter,
//             the register file and the decoder.
//  Contents : DEF_DATA_W / DEF_ADDR_W  default data and index widths
//             NUM_REGS                 architectural register count
//             REG_ZERO                 index of the hardwired-zero register
//  Revision : 1.0  initial release
// ============================================================================
package regfile_wb_arbiter_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int REG_ZERO   = 0;

endpackage : regfile_wb_arbiter_pkg
`default_nettype wire

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Round-robin arbiter with a one-hot combinational grant. The
//             search starts at the priority pointer and wraps modulo NUM_REQ.
//             The pointer moves one past the granted requester on each grant.
//  Ports    : clk    system clock, rising edge
//             rst    asynchronous, active-low reset (pointer -> 0)
//             req    request vector, one bit per requester
//             en     grant enable; when low the grant is all zeros
//             grant  one-hot grant (all zeros when nothing is granted)
//  Revision : 1.0  initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant
);

    localparam int                 PTR_W  = $clog2(NUM_REQ);
    localparam logic [PTR_W-1:0]   C_LAST = PTR_W'(NUM_REQ - 1);

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_gidx;
    logic [PTR_W-1:0] w_ptr_next;
    logic             w_found;

    // Scan from the pointer upward; the first valid requester wins.
    always_comb begin
        int               idx;
        logic [PTR_W-1:0] sel;
        grant   = '0;
        w_gidx  = '0;
        w_found = 1'b0;
        idx     = 0;
        sel     = '0;
        if (en) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = int'(r_ptr) + k;
                if (idx >= NUM_REQ) begin
                    idx = idx - NUM_REQ;
                end
                sel = PTR_W'(idx);
                if (!w_found && req[sel]) begin
                    grant[sel] = 1'b1;
                    w_gidx     = sel;
                    w_found    = 1'b1;
                end
            end
        end
    end

    // Explicit wrap: NUM_REQ need not be a power of two.
    assign w_ptr_next = (w_gidx == C_LAST) ? '0 : w_gidx + PTR_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= '0;
        end else if (w_found) begin
            r_ptr <= w_ptr_next;
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_wb_arbiter
//  Purpose  : Shares the register file write port between NUM_REQ writeback
//             requesters with a round-robin valid/ready handshake. The granted
//             write is registered onto rf_en / rf_rd_addr / rf_data_in. The
//             block also bypasses that in-flight write onto both read operands.
//  Ports    : clk, rst                 clock / async active-low reset
//             req_valid, req_ready     per-requester handshake
//             req_addr, req_data       packed per-requester index / data
//             wb_stall                 blocks all grants this cycle
//             rf_en, rf_rd_addr,
//             rf_data_in               registered register-file write port
//             rs1_addr, rs2_addr       read indices
//             rf_op_a, rf_op_b         raw register-file read data
//             op_a, op_b               bypassed operands
//  Revision : 1.0  initial release
// ============================================================================
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic                      wb_stall,
    output logic                      rf_en,
    output logic [ADDR_W-1:0]         rf_rd_addr,
    output logic [DATA_W-1:0]         rf_data_in,
    input  logic [ADDR_W-1:0]         rs1_addr,
    input  logic [ADDR_W-1:0]         rs2_addr,
    input  logic [DATA_W-1:0]         rf_op_a,
    input  logic [DATA_W-1:0]         rf_op_b,
    output logic [DATA_W-1:0]         op_a,
    output logic [DATA_W-1:0]         op_b
);

    localparam logic [ADDR_W-1:0] C_ZERO = ADDR_W'(REG_ZERO);

    logic              w_arb_en;
    logic              w_xfer;
    logic              w_wr;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_data;
    logic              r_rf_en;
    logic [ADDR_W-1:0] r_rf_rd_addr;
    logic [DATA_W-1:0] r_rf_data_in;

    // Gating with rst keeps req_ready low for the whole reset window.
    assign w_arb_en = rst & ~wb_stall;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .clk   (clk),
        .rst   (rst),
        .req   (req_valid),
        .en    (w_arb_en),
        .grant (req_ready)
    );

    // Grant is one-hot, so at most one slice is picked.
    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                w_sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                w_sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_xfer = |req_ready;
    // Writes to x0 complete the handshake but never reach the register file.
    assign w_wr   = w_xfer && (w_sel_addr != C_ZERO);

    // Address/data only load on a real write so the last committed write stays visible.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rf_en      <= 1'b0;
            r_rf_rd_addr <= '0;
            r_rf_data_in <= '0;
        end else begin
            r_rf_en <= w_wr;
            if (w_wr) begin
                r_rf_rd_addr <= w_sel_addr;
                r_rf_data_in <= w_sel_data;
            end
        end
    end

    assign rf_en      = r_rf_en;
    assign rf_rd_addr = r_rf_rd_addr;
    assign rf_data_in = r_rf_data_in;

    // Forward the write the register file has not committed yet.
    assign op_a = (r_rf_en && (r_rf_rd_addr == rs1_addr) && (rs1_addr != C_ZERO))
                  ? r_rf_data_in : rf_op_a;
    assign op_b = (r_rf_en && (r_rf_rd_addr == rs2_addr) && (rs2_addr != C_ZERO))
                  ? r_rf_data_in : rf_op_b;

endmodule : regfile_wb_arbiter
`default_nettype wire
